// File: rtl/music_requester.sv
// Music note requester: fetches 4-bit note codes over a two-wire handshake
// (data_rq / data_rd) and plays each code 1..8 as a square wave for a fixed
// note duration. Codes 0 and 9..15 are accepted but produce no sound.
module music_requester #(
    parameter int unsigned NOTE_LEN   = 25000000,
    parameter int unsigned TONE_SHIFT = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] sound_code,
    input  logic       data_rd,
    output logic       data_rq,
    output logic       tone_out,
    output logic       note_active,
    output logic [3:0] cur_code
);

    typedef enum logic [3:0] {
        S_REQ     = 4'b0001,
        S_ACK     = 4'b0010,
        S_PLAY    = 4'b0100,
        S_RELEASE = 4'b1000
    } state_t;

    // Last cycle of a note; the duration counter never passes this value.
    localparam logic [31:0] DUR_LAST = 32'(NOTE_LEN - 1);

    state_t      state;
    state_t      state_next;

    logic [16:0] half_cnt;
    logic [31:0] dur_cnt;

    logic [16:0] half_cnt_d;
    logic [31:0] dur_cnt_d;
    logic        data_rq_d;
    logic        tone_d;
    logic        note_active_d;
    logic [3:0]  cur_code_d;

    logic [16:0] half_len;
    logic        half_wrap;
    logic        stay_play;
    logic        audible;

    // Half-period of a note in clock cycles, scaled down by TONE_SHIFT and
    // kept at least 1 so the wrap compare below is always reachable.
    function automatic logic [16:0] half_period(input logic [3:0] code);
        logic [16:0] base;
        logic [16:0] scaled;
        case (code)
            4'd1:    base = 17'd95556;
            4'd2:    base = 17'd85131;
            4'd3:    base = 17'd75843;
            4'd4:    base = 17'd71586;
            4'd5:    base = 17'd63776;
            4'd6:    base = 17'd56818;
            4'd7:    base = 17'd50619;
            4'd8:    base = 17'd47778;
            default: base = 17'd1;
        endcase
        scaled = base >> TONE_SHIFT;
        return (scaled == 17'd0) ? 17'd1 : scaled;
    endfunction

    assign half_len  = half_period(cur_code);
    assign half_wrap = (half_cnt == half_len - 17'd1);
    assign audible   = (cur_code >= 4'd1) && (cur_code <= 4'd8);
    assign stay_play = (state == S_PLAY) && (state_next == S_PLAY);

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) state <= S_REQ;
        else       state <= state_next;
    end

    // Next-state logic for the request / acknowledge / play / release cycle.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch
        // is inferred.
        state_next = state;
        case (state)
            S_REQ:     if (data_rd) state_next = S_ACK;
            S_ACK:     if (!data_rd) state_next = audible ? S_PLAY : S_REQ;
            S_PLAY:    if (dur_cnt == DUR_LAST) state_next = S_RELEASE;
            S_RELEASE: state_next = S_REQ;
            default:   state_next = S_REQ;
        endcase
    end

    // Next values of the registered outputs and counters. Counters and the
    // tone restart from zero whenever the block is not staying in PLAY, so
    // each note starts low and rises exactly one half-period after entry.
    always_comb begin
        data_rq_d     = (state_next == S_REQ);
        note_active_d = (state_next == S_PLAY);
        cur_code_d    = cur_code;
        dur_cnt_d     = 32'd0;
        half_cnt_d    = 17'd0;
        tone_d        = 1'b0;

        if (state == S_REQ && data_rd) cur_code_d = sound_code;

        if (stay_play) begin
            dur_cnt_d  = dur_cnt + 32'd1;
            half_cnt_d = half_wrap ? 17'd0 : half_cnt + 17'd1;
            tone_d     = half_wrap ? ~tone_out : tone_out;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_rq     <= 1'b0;
            tone_out    <= 1'b0;
            note_active <= 1'b0;
            cur_code    <= 4'd0;
            dur_cnt     <= 32'd0;
            half_cnt    <= 17'd0;
        end else begin
            data_rq     <= data_rq_d;
            tone_out    <= tone_d;
            note_active <= note_active_d;
            cur_code    <= cur_code_d;
            dur_cnt     <= dur_cnt_d;
            half_cnt    <= half_cnt_d;
        end
    end

endmodule

// File: tb/tb_music_requester.sv
// Directed testbench for music_requester with NOTE_LEN=100, TONE_SHIFT=10.
// Half-periods at this shift: code1=93 code2=83 code3=74 code5=62
// code6=55 code8=46.
module tb_music_requester;

    localparam int NOTE_LEN   = 100;
    localparam int TONE_SHIFT = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] sound_code;
    logic       data_rd;
    logic       data_rq;
    logic       tone_out;
    logic       note_active;
    logic [3:0] cur_code;

    int n_checks = 0;
    int n_fail   = 0;

    music_requester #(
        .NOTE_LEN  (NOTE_LEN),
        .TONE_SHIFT(TONE_SHIFT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sound_code (sound_code),
        .data_rd    (data_rd),
        .data_rq    (data_rq),
        .tone_out   (tone_out),
        .note_active(note_active),
        .cur_code   (cur_code)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full note through the handshake, starting in REQ with data_rq=1.
    // data_rd stays high for 'hold' cycles; 'alt' is put on the bus mid-note;
    // 'glitch' pulses data_rd during PLAY.
    task automatic run_note(input logic [3:0] code, input int h, input int hold,
                            input logic [3:0] alt, input bit glitch);
        int rise;
        int fall;
        int active;
        int exp_fall;
        bit overlap;
        sound_code = code;
        data_rd    = 1'b1;
        tick();
        check("ack_rq", data_rq, 0);
        check("ack_code", cur_code, code);
        overlap = 1'b0;
        for (int i = 1; i < hold; i++) begin
            tick();
            if (data_rq || note_active) overlap = 1'b1;
        end
        data_rd = 1'b0;
        tick();
        check("ack_hold", overlap, 0);
        check("play_entry", note_active, 1);
        check("tone_entry", tone_out, 0);
        rise   = -1;
        fall   = -1;
        active = 1;
        for (int c = 1; c < NOTE_LEN; c++) begin
            if (c == 10) sound_code = alt;
            if (glitch && c == 20) data_rd = 1'b1;
            if (glitch && c == 25) data_rd = 1'b0;
            tick();
            if (note_active) active++;
            if (data_rq) overlap = 1'b1;
            if (tone_out && rise < 0) rise = c;
            if (!tone_out && rise >= 0 && fall < 0) fall = c;
        end
        exp_fall = (2 * h < NOTE_LEN) ? 2 * h : -1;
        check("tone_rise", rise, h);
        check("tone_fall", fall, exp_fall);
        check("note_len", active, NOTE_LEN);
        check("play_no_rq", overlap, 0);
        check("play_code", cur_code, code);
        tick();
        check("rel_note", note_active, 0);
        check("rel_tone", tone_out, 0);
        check("rel_rq", data_rq, 0);
        tick();
        check("req_rq", data_rq, 1);
        check("req_note", note_active, 0);
    endtask

    initial begin
        bit seen;
        logic [3:0] silent_codes [2];
        silent_codes[0] = 4'd0;
        silent_codes[1] = 4'd12;

        reset      = 1'b1;
        data_rd    = 1'b0;
        sound_code = 4'd0;
        tick();
        tick();
        check("rst_rq", data_rq, 0);
        check("rst_tone", tone_out, 0);
        check("rst_note", note_active, 0);
        check("rst_code", cur_code, 0);
        reset = 1'b0;
        tick();
        check("first_rq", data_rq, 1);

        // Basic note, bus changed to 9 mid-note.
        run_note(4'd6, 55, 2, 4'd9, 1'b0);

        // Silent codes return straight to REQ.
        foreach (silent_codes[k]) begin
            sound_code = silent_codes[k];
            data_rd    = 1'b1;
            tick();
            check("sil_ack_rq", data_rq, 0);
            check("sil_code", cur_code, silent_codes[k]);
            tick();
            data_rd = 1'b0;
            tick();
            check("sil_rq", data_rq, 1);
            seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (note_active || tone_out) seen = 1'b1;
                tick();
            end
            check("sil_quiet", seen, 0);
        end

        // data_rd held 20 cycles in ACK, plus a data_rd glitch during PLAY.
        run_note(4'd5, 62, 20, 4'd5, 1'b1);

        // Bus changes from 3 to 7 during PLAY.
        run_note(4'd3, 74, 2, 4'd7, 1'b0);

        // Back-to-back notes.
        run_note(4'd8, 46, 2, 4'd8, 1'b0);
        run_note(4'd1, 93, 2, 4'd1, 1'b0);
        run_note(4'd2, 83, 2, 4'd2, 1'b0);

        // Reset 30 cycles into a code-1 note.
        sound_code = 4'd1;
        data_rd    = 1'b1;
        tick();
        tick();
        data_rd = 1'b0;
        tick();
        check("rp_play", note_active, 1);
        for (int c = 1; c <= 30; c++) tick();
        reset = 1'b1;
        tick();
        check("rp_tone", tone_out, 0);
        check("rp_note", note_active, 0);
        check("rp_code", cur_code, 0);
        check("rp_rq", data_rq, 0);
        reset = 1'b0;
        tick();
        check("rp_first_rq", data_rq, 1);
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (tone_out || note_active || !data_rq) seen = 1'b1;
        end
        check("rp_quiet", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/music_requester.md
MUSIC_REQUESTER -- requirements
Module: music_requester

Interface
REQ-001 Parameter NOTE_LEN, default 25000000: note duration in clock cycles (0.5 s at 50 MHz); legal range is 2 and above.
REQ-002 Parameter TONE_SHIFT, default 0: every half-period table entry is right-shifted by TONE_SHIFT, for simulation speed-up.
REQ-003 clock  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sound_code  input  4  note code from the handshake block; valid while data_rd=1.
REQ-006 data_rd  input  1  data ready from the handshake block.
REQ-007 data_rq  output  1  data request to the handshake block; registered.
REQ-008 tone_out  output  1  square-wave audio output; registered.
REQ-009 note_active  output  1  high while a tone is being generated; registered.
REQ-010 cur_code  output  4  code of the most recently accepted note; registered.

Function
REQ-011 The block SHALL implement four one-hot states: REQ, ACK, PLAY and RELEASE.
REQ-012 REQ: data_rq=1; when data_rd=1 is sampled, the block SHALL latch sound_code into cur_code and go to ACK on the next edge.
REQ-013 ACK: data_rq=0; the block SHALL remain in ACK until data_rd=0 is sampled.
REQ-014 On leaving ACK, the block SHALL go to PLAY if cur_code is in 1..8, otherwise to REQ (silent code).
REQ-015 Silent code timing: a code of 0 or 9..15 SHALL produce no tone, and data_rq SHALL be 1 on the cycle after the ACK exit.
REQ-016 PLAY: note_active=1; a duration counter SHALL count NOTE_LEN cycles from PLAY entry, then the block SHALL go to RELEASE.
REQ-017 RELEASE: lasts exactly one cycle, with tone_out=0 and note_active=0; the block SHALL then go to REQ.
REQ-018 Half-period table, in cycles at 50 MHz:
  1=95556  2=85131  3=75843  4=71586  5=63776  6=56818  7=50619  8=47778.
  Each entry SHALL be right-shifted by TONE_SHIFT, and the shifted value SHALL be clamped to a minimum of 1.
REQ-019 Tone generation SHALL follow these rules:
  - tone_out=0 on PLAY entry.
  - A half-period counter SHALL run from 0 to H-1.
  - tone_out SHALL toggle on each wrap.
  - The first rising edge of tone_out SHALL occur H cycles after PLAY entry.
REQ-020 Counter widths: the half-period counter SHALL be 17 bits and the duration counter SHALL be 32 bits; neither counter SHALL wrap within its stated range.
REQ-021 data_rq SHALL be 0 in ACK, PLAY and RELEASE, so no new request is made during a note.
REQ-022 Stale-data handling: a data_rd that is already 1 on REQ entry SHALL be accepted, because the prior ACK guaranteed that data_rd fell in between.
REQ-023 sound_code SHALL be ignored in every state except REQ with data_rd=1.
REQ-024 Bus changes: a change of sound_code during ACK or PLAY SHALL NOT alter cur_code or the tone.
REQ-025 data_rd glitch during PLAY: a rise of data_rd in PLAY SHALL have no effect; the block SHALL wait for data_rd=0 only when in ACK.

Reset
REQ-026 On reset=1 at a clock edge, the block SHALL go to REQ with data_rq=0, tone_out=0, note_active=0, cur_code=0, and all counters cleared.
REQ-027 First request after reset: in the first cycle after reset is deasserted, data_rq SHALL become 1.
REQ-028 Reset during PLAY, ACK or RELEASE SHALL abort immediately with the same values as REQ-026, and no tone edge SHALL occur afterwards.

Verification
REQ-029 With NOTE_LEN=100 and TONE_SHIFT=10:
  - Stimulus: data_rd=1 with code 6 in REQ, then data_rd=0 two cycles later.
  - Response: cur_code=6, data_rq falls one cycle after data_rd rises, and note_active is high for 100 cycles.
  - Response: tone_out toggles every 55 cycles, and data_rq returns to 1 after RELEASE.
REQ-030 Code 0 accepted -> no note_active pulse, and data_rq is 1 on the cycle after data_rd falls.
REQ-031 data_rd held at 1 for 20 cycles in ACK -> the block stays in ACK with data_rq=0, and PLAY starts the cycle after data_rd falls.
REQ-032 Reset asserted 30 cycles into PLAY of code 1:
  - The next cycle shows tone_out=0, note_active=0 and cur_code=0.
  - data_rq=1 on the cycle after reset is released.
REQ-033 sound_code changed from 3 to 7 during PLAY -> the tone keeps the code-3 period (74 cycles at TONE_SHIFT=10), and cur_code stays 3.
REQ-034 Back-to-back codes 8, 1 and 2 through the handshake -> three notes in order, each separated by RELEASE and REQ, with no overlap of data_rq and note_active.
